pwm3_gen: RTL and testbench



---
 rtl/pwm3_pkg.sv | 15 +
 rtl/pwm3_cmp.sv | 44 ++++
 rtl/pwm3_gen.sv | 155 +++++++++++++++
 tb/tb_pwm3_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm3_pkg.sv
// pwm3_pkg: shared constants and state encoding for the three-phase PWM generator.
package pwm3_pkg;

  localparam int CNT_W_DEF = 12;
  localparam int NPH       = 3;
  localparam int P_MIN     = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_TRIP = 2'd3
  } state_t;

endpackage

// File: rtl/pwm3_cmp.sv
// pwm3_cmp: one phase leg -- shadow/active duty pair and registered complementary compare.
module pwm3_cmp
  import pwm3_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             load,
  input  logic             vld_p0,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] cnt,
  output logic             gh,
  output logic             gl
);

  logic [CNT_W-1:0] d_sh;
  logic [CNT_W-1:0] d_act;
  logic             hit_p0;

  // Unsigned compare; a duty at or above the half-period never drops below the carrier.
  assign hit_p0 = (cnt < d_act);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_sh  <= '0;
      d_act <= '0;
      gh    <= 1'b0;
      gl    <= 1'b0;
    end else begin
      if (wr) begin
        d_sh <= duty;
      end
      if (load) begin
        d_act <= d_sh;
      end
      // p0 -> p1: gate commands, forced off whenever the carrier is not running
      gh <= vld_p0 & hit_p0;
      gl <= vld_p0 & ~hit_p0;
    end
  end

endmodule

// File: rtl/pwm3_gen.sv
// pwm3_gen: three-phase center-aligned PWM with valley-synchronous double-buffered updates.
// Define PWM3_TRIP_EN to add the trip_n fault input, the fault output and the TRIP state.
module pwm3_gen
  import pwm3_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_a,
  input  logic [CNT_W-1:0] duty_b,
  input  logic [CNT_W-1:0] duty_c,
  input  logic             wr,
  output logic             upd_pend,
  output logic             sync,
  output logic [NPH-1:0]   gh,
  output logic [NPH-1:0]   gl
`ifdef PWM3_TRIP_EN
  ,
  input  logic             trip_n,
  output logic             fault
`endif
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] p_sh;
  logic [CNT_W-1:0] p_act;
  logic [CNT_W-1:0] p_eff;
  logic             trip_hit;
  logic             valley;
  logic             load;
  logic             vld_p0;
  logic [CNT_W-1:0] duty [NPH];

  // A zero half-period would never reach its turning point; run it as the minimum instead.
  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(P_MIN)) ? CNT_W'(P_MIN) : p;
  endfunction

`ifdef PWM3_TRIP_EN
  assign trip_hit = ~trip_n;
  assign fault    = (state == ST_TRIP);
`else
  assign trip_hit = 1'b0;
`endif

  assign p_eff  = clamp_period(p_act);
  assign vld_p0 = ((state == ST_UP) || (state == ST_DOWN)) && en && !trip_hit;
  assign valley = (state == ST_DOWN) && (cnt == '0) && en && !trip_hit;
  assign load   = upd_pend && ((state == ST_IDLE) || valley);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (trip_hit) begin
      state_nx = ST_TRIP;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nx = '0;
          if (en) state_nx = ST_UP;
        end
        ST_UP: begin
          if (!en) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end else if (cnt == p_eff - CNT_W'(1)) begin
            state_nx = ST_DOWN;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          if (!en) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end else if (cnt == '0) begin
            state_nx = ST_UP;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
        ST_TRIP: begin
          // Leaving a fault needs the operator to drop enable with the trip already cleared.
          cnt_nx = '0;
          if (!en) state_nx = ST_IDLE;
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Shadow write wins over the transfer clear, so a write on the load edge stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sh     <= '0;
      p_act    <= CNT_W'(P_MIN);
      upd_pend <= 1'b0;
      sync     <= 1'b0;
    end else begin
      if (wr) begin
        p_sh <= period;
      end
      if (load) begin
        p_act <= p_sh;
      end
      if (wr) begin
        upd_pend <= 1'b1;
      end else if (load) begin
        upd_pend <= 1'b0;
      end
      sync <= valley;
    end
  end

  assign duty[0] = duty_a;
  assign duty[1] = duty_b;
  assign duty[2] = duty_c;

  for (genvar i = 0; i < NPH; i++) begin : g_ph
    pwm3_cmp #(
      .CNT_W (CNT_W)
    ) u_cmp (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr     (wr),
      .load   (load),
      .vld_p0 (vld_p0),
      .duty   (duty[i]),
      .cnt    (cnt),
      .gh     (gh[i]),
      .gl     (gl[i])
    );
  end

endmodule

// File: tb/tb_pwm3_gen.sv
// tb_pwm3_gen: directed bench for pwm3_gen with a carrier-position reference model.
module tb_pwm3_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] period;
  logic [11:0] duty_a;
  logic [11:0] duty_b;
  logic [11:0] duty_c;
  logic        wr;
  logic        upd_pend;
  logic        sync;
  logic [2:0]  gh;
  logic [2:0]  gl;
`ifdef PWM3_TRIP_EN
  logic        trip_n;
  logic        fault;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_on = 0;

  pwm3_gen #(.CNT_W(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .period   (period),
    .duty_a   (duty_a),
    .duty_b   (duty_b),
    .duty_c   (duty_c),
    .wr       (wr),
    .upd_pend (upd_pend),
    .sync     (sync),
    .gh       (gh),
    .gl       (gl)
`ifdef PWM3_TRIP_EN
    ,
    .trip_n   (trip_n),
    .fault    (fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position k in a 2P-clock period, k = 0 is the first cycle after the valley.
  // A gate is high when k lies within D clocks of either side of the valley.
  int   m_p, sh_p, m_pos;
  int   m_d [3];
  int   sh_d [3];
  bit   m_run, m_trip, m_pend;
  logic [2:0] e_gh, e_gl;
  bit   e_sync, e_fault;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p = 1; sh_p = 0; m_pos = 0;
      for (int i = 0; i < 3; i++) begin m_d[i] = 0; sh_d[i] = 0; end
      m_run = 0; m_trip = 0; m_pend = 0;
      e_gh = '0; e_gl = '0; e_sync = 0; e_fault = 0;
    end else begin
      bit trip, act, valley, ld;
      int per;
`ifdef PWM3_TRIP_EN
      trip = !trip_n;
`else
      trip = 0;
`endif
      act = m_run && en && !trip;
      per = 2 * m_p;
      for (int i = 0; i < 3; i++) begin
        e_gh[i] = act && ((m_pos < m_d[i]) || (m_pos >= per - m_d[i]));
        e_gl[i] = act && !e_gh[i];
      end
      valley = act && (m_pos == per - 1);
      ld     = m_pend && ((!m_run && !m_trip) || valley);
      e_sync = valley;
      if (trip) begin
        m_trip = 1; m_run = 0;
      end else if (m_trip) begin
        if (!en) m_trip = 0;
      end else if (!en) begin
        m_run = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % per;
      end
      if (ld) begin
        m_p = (sh_p == 0) ? 1 : sh_p;
        for (int i = 0; i < 3; i++) m_d[i] = sh_d[i];
      end
      if (wr) begin
        sh_p = int'(period);
        sh_d[0] = int'(duty_a); sh_d[1] = int'(duty_b); sh_d[2] = int'(duty_c);
        m_pend = 1;
      end else if (ld) begin
        m_pend = 0;
      end
      e_fault = m_trip;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("gh", {29'd0, gh}, {29'd0, e_gh});
      chk("gl", {29'd0, gl}, {29'd0, e_gl});
      chk("sync", {31'd0, sync}, {31'd0, e_sync});
      chk("upd_pend", {31'd0, upd_pend}, {31'd0, m_pend});
`ifdef PWM3_TRIP_EN
      chk("fault", {31'd0, fault}, {31'd0, e_fault});
`endif
    end
  end

  task automatic wait_sync(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sync && k < 3000);
    chk({tag, "_sync_seen"}, {31'd0, sync}, 32'd1);
  endtask

  task automatic sync_gap(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sync && k < 3000);
  endtask

  task automatic count_win(input int n, output int h0, output int h1, output int h2,
                           output int l0, output int s);
    h0 = 0; h1 = 0; h2 = 0; l0 = 0; s = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      h0 += int'(gh[0]); h1 += int'(gh[1]); h2 += int'(gh[2]);
      l0 += int'(gl[0]); s  += int'(sync);
    end
  endtask

  task automatic write_regs(input int p, input int da, input int db, input int dc);
    period = 12'(p); duty_a = 12'(da); duty_b = 12'(db); duty_c = 12'(dc);
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end

  initial begin
    int h0, h1, h2, l0, s, gap;
    rst_n = 1'b0; en = 1'b0; wr = 1'b0;
    period = '0; duty_a = '0; duty_b = '0; duty_c = '0;
`ifdef PWM3_TRIP_EN
    trip_n = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_gh", {29'd0, gh}, 32'd0);
    chk("rst_gl", {29'd0, gl}, 32'd0);
    chk("rst_pend", {31'd0, upd_pend}, 32'd0);
    chk("rst_sync", {31'd0, sync}, 32'd0);
    rst_n = 1'b1;
    mon_on = 1'b1;

    // Basic run: P=500, D=250/125/0
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    write_regs(500, 250, 125, 0);
    wait_sync("first");
    sync_gap(gap);
    chk("sync_interval", gap, 1000);
    count_win(1000, h0, h1, h2, l0, s);
    chk("basic_gh0", h0, 500);
    chk("basic_gh1", h1, 250);
    chk("basic_gh2", h2, 0);
    chk("basic_gl0", l0, 500);
    chk("basic_sync_cnt", s, 1);

    // Duty above the half-period saturates high
    @(negedge clk);
    write_regs(500, 600, 125, 0);
    wait_sync("sat");
    count_win(2000, h0, h1, h2, l0, s);
    chk("sat_gh0", h0, 2000);
    chk("sat_gl0", l0, 0);
    chk("sat_sync_cnt", s, 2);

    // Mid-period write at CNT=300 in UP
    repeat (300) @(negedge clk);
    write_regs(500, 100, 125, 0);
    chk("mid_pend", {31'd0, upd_pend}, 32'd1);
    wait_sync("mid");
    chk("mid_pend_clr", {31'd0, upd_pend}, 32'd0);
    count_win(1000, h0, h1, h2, l0, s);
    chk("mid_gh0", h0, 200);

    // Write coincident with the valley transfer edge
    repeat (100) @(negedge clk);
    write_regs(500, 50, 125, 0);
    repeat (898) @(negedge clk);
    write_regs(500, 400, 125, 0);
    chk("coin_sync", {31'd0, sync}, 32'd1);
    chk("coin_pend", {31'd0, upd_pend}, 32'd1);
    count_win(1000, h0, h1, h2, l0, s);
    chk("coin_old_gh0", h0, 100);
    count_win(1000, h0, h1, h2, l0, s);
    chk("coin_new_gh0", h0, 800);
    chk("coin_pend_clr", {31'd0, upd_pend}, 32'd0);

    // Enable dropped in DOWN, then restart
    repeat (700) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("dis_gh", {29'd0, gh}, 32'd0);
    chk("dis_gl", {29'd0, gl}, 32'd0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_sync("restart");
    count_win(1000, h0, h1, h2, l0, s);
    chk("restart_gh0", h0, 800);
    chk("restart_gh1", h1, 250);

    // Asynchronous reset in UP with a pending write
    @(negedge clk);
    write_regs(500, 400, 300, 0);
    repeat (98) @(negedge clk);
    chk("pre_rst_gh0", {31'd0, gh[0]}, 32'd1);
    chk("pre_rst_pend", {31'd0, upd_pend}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gh", {29'd0, gh}, 32'd0);
    chk("arst_gl", {29'd0, gl}, 32'd0);
    chk("arst_pend", {31'd0, upd_pend}, 32'd0);
    chk("arst_sync", {31'd0, sync}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // P=0 runs as P=1: period of two clocks, D=1 continuously high
    @(negedge clk);
    en = 1'b1;
    write_regs(0, 1, 0, 3);
    wait_sync("p0");
    sync_gap(gap);
    chk("p0_interval", gap, 2);
    count_win(10, h0, h1, h2, l0, s);
    chk("p0_gh0", h0, 10);
    chk("p0_gh1", h1, 0);
    chk("p0_sync_cnt", s, 5);

`ifdef PWM3_TRIP_EN
    // Trip entry, hold while enabled, exit on EN=0 with TRIP_N=1
    write_regs(20, 10, 5, 20);
    wait_sync("trip");
    repeat (5) @(negedge clk);
    trip_n = 1'b0;
    @(negedge clk);
    chk("trip_fault", {31'd0, fault}, 32'd1);
    chk("trip_gh", {29'd0, gh}, 32'd0);
    chk("trip_gl", {29'd0, gl}, 32'd0);
    trip_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("trip_hold", {31'd0, fault}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("trip_exit", {31'd0, fault}, 32'd0);
`endif

    repeat (4) @(negedge clk);
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
